// File: rtl/load_store_unit.sv
// Load/store initiator for the data memory: one request at a time, sized and
// sign/zero-extended loads, read-modify-write for sub-doubleword stores.

module load_store_unit_checker (
   input logic clk,
   input logic reset,
   input logic mem_write,
   input logic mem_read,
   input logic resp_valid,
   input logic resp_error
);

   a_strobe_exclusive: assert property (@(posedge clk) disable iff (reset)
      !(mem_write && mem_read));

   a_resp_single_pulse: assert property (@(posedge clk) disable iff (reset)
      resp_valid |=> !resp_valid);

   a_error_qualified: assert property (@(posedge clk) disable iff (reset)
      resp_error |-> resp_valid);

   a_error_no_strobes: assert property (@(posedge clk) disable iff (reset)
      resp_error |-> (!mem_write && !mem_read));

endmodule

module load_store_unit #(
   parameter int MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_error,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_write,
   output logic        mem_read,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_t;

   // Every access spans 8 bytes, so the last legal start address is MEM_BYTES-8.
   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

   function automatic logic [63:0] load_extend(input logic [2:0] f3, input logic [63:0] d);
      logic [63:0] r;
      r = 64'd0;
      case (f3)
         3'b000:  r = {{56{d[7]}}, d[7:0]};
         3'b001:  r = {{48{d[15]}}, d[15:0]};
         3'b010:  r = {{32{d[31]}}, d[31:0]};
         3'b011:  r = d;
         3'b100:  r = {56'd0, d[7:0]};
         3'b101:  r = {48'd0, d[15:0]};
         3'b110:  r = {32'd0, d[31:0]};
         default: r = 64'd0;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] store_merge(input logic [2:0] f3, input logic [63:0] old,
                                               input logic [63:0] wd);
      logic [63:0] r;
      r = wd;
      case (f3)
         3'b000:  r = {old[63:8], wd[7:0]};
         3'b001:  r = {old[63:16], wd[15:0]};
         3'b010:  r = {old[63:32], wd[31:0]};
         default: r = wd;
      endcase
      return r;
   endfunction

   function automatic logic funct3_illegal(input logic write, input logic [2:0] f3);
      logic r;
      if (write) begin
         r = f3[2];
      end else begin
         r = (f3 == 3'b111);
      end
      return r;
   endfunction

   state_t      state_r, state_s;
   logic [63:0] addr_r, addr_s;
   logic        write_r, write_s;
   logic [2:0]  funct3_r, funct3_s;
   logic [63:0] wdata_r, wdata_s;

   logic        resp_valid_s;
   logic [63:0] resp_rdata_s;
   logic        resp_error_s;
   logic [63:0] mem_addr_s;
   logic [63:0] mem_wdata_s;
   logic        mem_write_s;
   logic        mem_read_s;

   logic        accept_s;
   logic        bad_req_s;

   assign req_ready = (state_r == IDLE) && !reset;
   assign accept_s  = req_valid && req_ready;
   assign bad_req_s = funct3_illegal(req_write, req_funct3) || (req_addr > LAST_ADDR);

   // Next-state and next registered-output logic; outputs are computed one state ahead.
   always_comb begin
      state_s      = state_r;
      addr_s       = addr_r;
      write_s      = write_r;
      funct3_s     = funct3_r;
      wdata_s      = wdata_r;
      resp_valid_s = 1'b0;
      resp_rdata_s = resp_rdata;
      resp_error_s = 1'b0;
      mem_addr_s   = mem_addr;
      mem_wdata_s  = mem_wdata;
      mem_write_s  = 1'b0;
      mem_read_s   = 1'b0;

      case (state_r)
         IDLE: begin
            if (accept_s) begin
               addr_s   = req_addr;
               write_s  = req_write;
               funct3_s = req_funct3;
               wdata_s  = req_wdata;
               if (bad_req_s) begin
                  state_s      = RESP;
                  resp_valid_s = 1'b1;
                  resp_error_s = 1'b1;
                  resp_rdata_s = 64'd0;
               end else if (req_write && (req_funct3 == 3'b011)) begin
                  state_s     = WR;
                  mem_addr_s  = req_addr;
                  mem_wdata_s = req_wdata;
                  mem_write_s = 1'b1;
               end else begin
                  state_s    = RD;
                  mem_addr_s = req_addr;
                  mem_read_s = 1'b1;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RD: begin
            state_s    = CAP;
            mem_read_s = 1'b1;
         end
         CAP: begin
            if (write_r) begin
               state_s     = WR;
               mem_addr_s  = addr_r;
               mem_wdata_s = store_merge(funct3_r, mem_rdata, wdata_r);
               mem_write_s = 1'b1;
            end else begin
               state_s      = RESP;
               resp_valid_s = 1'b1;
               resp_rdata_s = load_extend(funct3_r, mem_rdata);
            end
         end
         WR: begin
            state_s      = RESP;
            resp_valid_s = 1'b1;
            resp_rdata_s = 64'd0;
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, captured request and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         addr_r     <= 64'd0;
         write_r    <= 1'b0;
         funct3_r   <= 3'd0;
         wdata_r    <= 64'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 64'd0;
         resp_error <= 1'b0;
         mem_addr   <= 64'd0;
         mem_wdata  <= 64'd0;
         mem_write  <= 1'b0;
         mem_read   <= 1'b0;
      end else begin
         state_r    <= state_s;
         addr_r     <= addr_s;
         write_r    <= write_s;
         funct3_r   <= funct3_s;
         wdata_r    <= wdata_s;
         resp_valid <= resp_valid_s;
         resp_rdata <= resp_rdata_s;
         resp_error <= resp_error_s;
         mem_addr   <= mem_addr_s;
         mem_wdata  <= mem_wdata_s;
         mem_write  <= mem_write_s;
         mem_read   <= mem_read_s;
      end
   end

   load_store_unit_checker u_checker (
      .clk        (clk),
      .reset      (reset),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .resp_valid (resp_valid),
      .resp_error (resp_error)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-array reference memory model,
// randomized and directed requests, monitor checks responses and write data.

module tb_load_store_unit;

   localparam int MEM_BYTES = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [63:0] req_addr = 64'd0;
   logic [63:0] req_wdata = 64'd0;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_error;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_write;
   logic        mem_read;
   logic [63:0] mem_rdata;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_error (resp_error),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .mem_rdata  (mem_rdata)
   );

   // Attached data memory: combinational little-endian read, 8-byte write on the edge.
   logic [7:0] mem [0:MEM_BYTES-1];
   logic       mem_init = 1'b1;

   always_comb begin
      mem_rdata = 64'd0;
      for (int i = 0; i < 8; i++) begin
         if (int'(mem_addr[5:0]) + i < MEM_BYTES && mem_addr < 64'(MEM_BYTES))
            mem_rdata[8*i +: 8] = mem[int'(mem_addr[5:0]) + i];
      end
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
      end else if (mem_write && mem_addr <= 64'(MEM_BYTES - 8)) begin
         for (int i = 0; i < 8; i++) mem[int'(mem_addr[5:0]) + i] <= mem_wdata[8*i +: 8];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
      int          acc;
      int          n_rd;
      int          n_wr;
      logic [63:0] wdata;
      logic [63:0] addr;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] model_mem [0:MEM_BYTES-1];
   int checks = 0;
   int errors = 0;
   int last_resp_cyc = -100;
   int rd_cnt = 0;
   int wr_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the access rules: size = 1<<funct3[1:0] bytes.
   function automatic exp_t model_req(input logic w, input logic [2:0] f3,
                                      input logic [63:0] a, input logic [63:0] wd);
      exp_t e;
      int nbytes;
      logic [63:0] v;
      e.rdata = 64'd0; e.err = 1'b0; e.lat = 0; e.acc = 0;
      e.n_rd = 0; e.n_wr = 0; e.wdata = 64'd0; e.addr = a;
      if ((w && f3 >= 3'd4) || (!w && f3 == 3'd7) || a > 64'(MEM_BYTES - 8)) begin
         e.err = 1'b1;
         e.lat = 1;
         return e;
      end
      nbytes = 1 << f3[1:0];
      if (!w) begin
         v = 64'd0;
         for (int i = 0; i < nbytes; i++)
            v = v | (64'(model_mem[int'(a[5:0]) + i]) << (8 * i));
         if (f3 < 3'd4 && nbytes < 8 && v[8*nbytes-1])
            v = v | ~((64'd1 << (8 * nbytes)) - 64'd1);
         e.rdata = v;
         e.lat = 3;
         e.n_rd = 2;
      end else begin
         for (int i = 0; i < nbytes; i++)
            model_mem[int'(a[5:0]) + i] = wd[8*i +: 8];
         for (int i = 0; i < 8; i++)
            e.wdata[8*i +: 8] = model_mem[int'(a[5:0]) + i];
         e.lat  = (nbytes == 8) ? 4 - 2 : 4;
         e.n_rd = (nbytes == 8) ? 0 : 2;
         e.n_wr = 1;
      end
      return e;
   endfunction

   // Monitor: strobe bookkeeping each cycle, scoreboard pop on every response.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            rd_cnt = 0;
            wr_cnt = 0;
         end else begin
            if (mem_read || mem_write)
               check("strobe_exclusive", 64'(mem_read && mem_write), 64'd0);
            if (mem_read) rd_cnt++;
            if (mem_write) begin
               wr_cnt++;
               check("write_expected", 64'(sb_q.size() != 0), 64'd1);
               if (sb_q.size() != 0) begin
                  check("mem_wdata", mem_wdata, sb_q[0].wdata);
                  check("mem_addr_wr", mem_addr, sb_q[0].addr);
               end
            end
            if (resp_valid) begin
               check("resp_expected", 64'(sb_q.size() != 0), 64'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  check("resp_rdata", resp_rdata, e.rdata);
                  check("resp_error", 64'(resp_error), 64'(e.err));
                  check("latency", 64'(cyc - e.acc), 64'(e.lat));
                  check("read_cycles", 64'(rd_cnt), 64'(e.n_rd));
                  check("write_cycles", 64'(wr_cnt), 64'(e.n_wr));
               end
               last_resp_cyc = cyc;
               rd_cnt = 0;
               wr_cnt = 0;
            end
         end
      end
   end

   // Present a request and return right after its accept edge; req_valid stays high.
   task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, output int acc);
      exp_t e;
      bit got;
      got = 1'b0;
      acc = -1;
      req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
      req_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_timeout", 64'(got), 64'd1);
      if (got) begin
         acc = cyc;
         e = model_req(w, f3, a, wd);
         e.acc = cyc;
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (sb_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic one(input logic w, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd);
      int acc;
      do_req(w, f3, a, wd, acc);
      drain();
   endtask

   initial begin
      int acc1;
      int acc2;
      int resp1;
      logic [63:0] a;
      logic [63:0] word_act;
      logic [63:0] word_exp;

      for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_rdata", resp_rdata, 64'd0);
      check("rst_resp_error", 64'(resp_error), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      check("rst_strobes", 64'({mem_write, mem_read}), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      mem_init = 1'b0;
      @(negedge clk);
      check("idle_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1;

      one(1'b0, 3'b011, 64'h08, 64'd0);                   // ld 0x08
      one(1'b0, 3'b010, 64'h38, 64'd0);                   // lw 0x38
      one(1'b0, 3'b010, 64'h39, 64'd0);                   // lw 0x39 out of range
      one(1'b1, 3'b000, 64'h05, 64'hFF);                  // sb
      one(1'b0, 3'b000, 64'h05, 64'd0);                   // lb
      one(1'b0, 3'b100, 64'h05, 64'd0);                   // lbu
      one(1'b0, 3'b011, 64'h00, 64'd0);                   // ld 0x00
      one(1'b1, 3'b001, 64'h20, 64'hABCD1234);            // sh
      one(1'b0, 3'b011, 64'h20, 64'd0);
      one(1'b1, 3'b011, 64'h10, 64'h1122334455667788);    // sd
      one(1'b0, 3'b011, 64'h10, 64'd0);
      one(1'b0, 3'b111, 64'h00, 64'd0);                   // illegal load
      one(1'b1, 3'b100, 64'h00, 64'd5);                   // illegal store
      one(1'b0, 3'b110, 64'h38, 64'd0);                   // lwu at last legal address

      // Reset during CAP of an sw: request is dropped, memory untouched.
      req_write = 1'b1; req_funct3 = 3'b010; req_addr = 64'h18;
      req_wdata = 64'hDEADBEEFCAFEF00D; req_valid = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req_ready) break;
      end
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      check("post_rst_mem_write", 64'(mem_write), 64'd0);
      check("post_rst_mem_read", 64'(mem_read), 64'd0);
      check("post_rst_resp_valid", 64'(resp_valid), 64'd0);
      check("post_rst_ready", 64'(req_ready), 64'd1);
      repeat (6) @(negedge clk);
      @(posedge clk); #1;
      one(1'b0, 3'b011, 64'h18, 64'd0);

      // Back-to-back with req_valid held high.
      do_req(1'b0, 3'b011, 64'h08, 64'd0, acc1);
      do_req(1'b0, 3'b001, 64'h0E, 64'd0, acc2);
      resp1 = last_resp_cyc;
      check("b2b_accept_cycle", 64'(acc2), 64'(resp1 + 1));
      drain();

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 7) == 0) a = {$urandom, $urandom};
         else a = 64'($urandom_range(0, 62));
         one(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom});
      end

      for (int w = 0; w < MEM_BYTES / 8; w++) begin
         for (int i = 0; i < 8; i++) begin
            word_act[8*i +: 8] = mem[8*w + i];
            word_exp[8*i +: 8] = model_mem[8*w + i];
         end
         check("final_mem_word", word_act, word_exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
